// File: rtl/irq_vector_arbiter_if.sv
// CPU register window, pending vector and IRQ/EOI signals of the vector arbiter.
// The master modport is the CPU/controller side; the slave modport is the arbiter.
interface irq_vector_arbiter_if #(
  parameter int NUM_IRQ = 256
) ();
  logic [7:0]         i_data;
  logic [7:0]         o_data;
  logic [1:0]         addr;
  logic               cs;
  logic               rwb;
  logic [NUM_IRQ-1:0] i_pending;
  logic               o_irq;
  logic               o_eoi;
  logic [7:0]         o_eoi_num;

  modport master (
    output i_data, addr, cs, rwb, i_pending,
    input  o_data, o_irq, o_eoi, o_eoi_num
  );

  modport slave (
    input  i_data, addr, cs, rwb, i_pending,
    output o_data, o_irq, o_eoi, o_eoi_num
  );
endinterface

// File: rtl/irq_vector_arbiter.sv
// Picks the lowest-index pending IRQ with a chunked, wrapping scan and drives the 6502 IRQ line.
// The CPU acknowledges by reading VECTOR and retires the interrupt with an EOI write.
module irq_vector_arbiter #(
  parameter int NUM_IRQ = 256,
  parameter int CHUNK   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  irq_vector_arbiter_if.slave  bus
);

  localparam int NUM_CHUNKS = NUM_IRQ / CHUNK;
  localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IW         = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2,
    INSVC = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          enable_q, enable_d;
  logic [7:0]    vector_q, vector_d;
  logic [KW-1:0] k_q, k_d;
  logic          irq_q, irq_d;
  logic          eoi_q, eoi_d;
  logic [7:0]    eoi_num_q, eoi_num_d;

  logic [CHUNK-1:0] chunk_bits;
  logic [IW-1:0]    chunk_idx;
  logic [7:0]       hit_vec;
  logic             pend_bit;
  logic             vec_rd, eoi_wr, ctrl_wr;
  logic             unused_data;

  assign unused_data = ^bus.i_data[7:1];

  assign vec_rd  = bus.cs &&  bus.rwb && (bus.addr == 2'd0);
  assign eoi_wr  = bus.cs && !bus.rwb && (bus.addr == 2'd2) && (state_q == INSVC);
  assign ctrl_wr = bus.cs && !bus.rwb && (bus.addr == 2'd3);

  // Live chunk slice; the descending loop leaves the lowest set bit in chunk_idx.
  always_comb begin
    chunk_bits = bus.i_pending[k_q*CHUNK +: CHUNK];
    chunk_idx  = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_bits[i]) chunk_idx = IW'(i);
    end
  end

  assign hit_vec  = 8'(int'(k_q) * CHUNK + int'(chunk_idx));
  assign pend_bit = bus.i_pending[vector_q];

  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    vector_d  = vector_q;
    k_d       = k_q;
    eoi_d     = 1'b0;
    eoi_num_d = eoi_num_q;

    if (ctrl_wr) enable_d = bus.i_data[0];

    case (state_q)
      IDLE: begin
        if (enable_d) begin
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        if (!enable_d) begin
          state_d = IDLE;
        end else if (|chunk_bits) begin
          vector_d = hit_vec;
          state_d  = VALID;
        end else begin
          k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
        end
      end
      VALID: begin
        // The ack beats a same-cycle withdrawal of the source bit.
        if (!enable_d)     state_d = IDLE;
        else if (vec_rd)   state_d = INSVC;
        else if (!pend_bit) state_d = IDLE;
      end
      INSVC: begin
        if (eoi_wr) begin
          state_d   = IDLE;
          eoi_d     = 1'b1;
          eoi_num_d = vector_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // IRQ rises one cycle after entering VALID and drops on the edge that leaves it.
    irq_d = (state_q == VALID) && (state_d == VALID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      vector_q  <= '0;
      k_q       <= '0;
      irq_q     <= 1'b0;
      eoi_q     <= 1'b0;
      eoi_num_q <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      vector_q  <= vector_d;
      k_q       <= k_d;
      irq_q     <= irq_d;
      eoi_q     <= eoi_d;
      eoi_num_q <= eoi_num_d;
    end
  end

  always_comb begin
    bus.o_data = 8'h00;
    case (bus.addr)
      2'd0:    bus.o_data = vector_q;
      2'd1:    bus.o_data = {state_q == VALID, state_q == INSVC, state_q == SCAN, enable_q, 4'b0};
      2'd3:    bus.o_data = {7'b0, enable_q};
      default: bus.o_data = 8'h00;
    endcase
  end

  assign bus.o_irq     = irq_q;
  assign bus.o_eoi     = eoi_q;
  assign bus.o_eoi_num = eoi_num_q;

endmodule

// File: tb/tb_irq_vector_arbiter.sv
// Directed bench for irq_vector_arbiter: stimulus pushes expected read data and EOI numbers
// into queues, and a negedge monitor pops and compares them as the DUT presents them.
module tb_irq_vector_arbiter;

  localparam int NUM_IRQ = 256;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t rd_q[$];
  exp_t eoi_q[$];

  irq_vector_arbiter_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  irq_vector_arbiter #(.NUM_IRQ(NUM_IRQ), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares each register read and each EOI pulse against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.cs && bus.rwb) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected addr=%0d got=%02h required=none", bus.addr, bus.o_data);
      end else begin
        e = rd_q.pop_front();
        if (bus.o_data !== e.val) begin
          errors++;
          $display("FAIL %s got=%02h required=%02h", e.tag, bus.o_data, e.val);
        end else begin
          $display("read  %s addr=%0d data=%02h ok", e.tag, bus.addr, bus.o_data);
        end
      end
    end
    if (bus.o_eoi) begin
      checks++;
      if (eoi_q.size() == 0) begin
        errors++;
        $display("FAIL eoi_unexpected got num=%0d required=no pulse", bus.o_eoi_num);
      end else begin
        e = eoi_q.pop_front();
        if (bus.o_eoi_num !== e.val) begin
          errors++;
          $display("FAIL %s got=%0d required=%0d", e.tag, bus.o_eoi_num, e.val);
        end else begin
          $display("eoi   %s num=%0d ok", e.tag, bus.o_eoi_num);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", tag, act, exp);
    end else begin
      $display("check %s value=%0h ok", tag, act);
    end
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [7:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    rd_q.push_back(e);
    bus.addr = a;
    bus.rwb  = 1'b1;
    bus.cs   = 1'b1;
    tick();
    bus.cs   = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.addr   = a;
    bus.i_data = d;
    bus.rwb    = 1'b0;
    bus.cs     = 1'b1;
    tick();
    bus.cs     = 1'b0;
    bus.rwb    = 1'b1;
  endtask

  task automatic expect_eoi(input logic [7:0] num, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = num;
    eoi_q.push_back(e);
  endtask

  task automatic wait_irq(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.o_irq !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.o_irq), 32'(lvl));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pend_only(input int b);
    bus.i_pending    = '0;
    bus.i_pending[b] = 1'b1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.cs        = 1'b0;
    bus.rwb       = 1'b1;
    bus.addr      = 2'd0;
    bus.i_data    = 8'h00;
    bus.i_pending = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_irq", 32'(bus.o_irq), 0);
    check("rst_eoi", 32'(bus.o_eoi), 0);
    check("rst_eoi_num", 32'(bus.o_eoi_num), 0);
    cpu_read(2'd1, 8'h00, "rst_status");
    cpu_read(2'd0, 8'h00, "rst_vector");

    // 1) enable, pend 37
    cpu_write(2'd3, 8'h01);
    pend_only(37);
    wait_irq(1'b1, 38, "t1_irq_rise");
    cpu_read(2'd1, 8'h90, "t1_status_valid");
    cpu_read(2'd0, 8'd37, "t1_vector");
    cpu_read(2'd1, 8'h50, "t1_status_insvc");
    check("t1_irq_after_ack", 32'(bus.o_irq), 0);

    // 2) 200 and 9 together, scan restarts at chunk 0 after EOI
    bus.i_pending      = '0;
    bus.i_pending[200] = 1'b1;
    bus.i_pending[9]   = 1'b1;
    expect_eoi(8'd37, "t1_eoi");
    cpu_write(2'd2, 8'h00);
    wait_irq(1'b1, 40, "t2_irq9");
    cpu_read(2'd0, 8'd9, "t2_vector9");
    bus.i_pending[9] = 1'b0;
    expect_eoi(8'd9, "t2_eoi9");
    cpu_write(2'd2, 8'hA5);
    check("t2_eoi_pulse", 32'(bus.o_eoi), 1);
    check("t2_eoi_num", 32'(bus.o_eoi_num), 9);
    tick();
    check("t2_eoi_one_cycle", 32'(bus.o_eoi), 0);
    check("t2_eoi_num_hold", 32'(bus.o_eoi_num), 9);
    wait_irq(1'b1, 40, "t2_irq200");
    cpu_read(2'd0, 8'd200, "t2_vector200");
    bus.i_pending = '0;
    expect_eoi(8'd200, "t2_eoi200");
    cpu_write(2'd2, 8'h00);

    // 3) withdraw source while VALID
    pend_only(5);
    wait_irq(1'b1, 40, "t3_irq5");
    bus.i_pending = '0;
    tick();
    check("t3_irq_fall", 32'(bus.o_irq), 0);
    tick();
    cpu_read(2'd1, 8'h30, "t3_status_rescan");

    // 4) EOI in IDLE and in VALID is ignored
    cpu_write(2'd3, 8'h00);
    cpu_write(2'd2, 8'h00);
    cpu_read(2'd1, 8'h00, "t4_status_idle");
    cpu_write(2'd3, 8'h01);
    pend_only(5);
    wait_irq(1'b1, 40, "t4_irq5");
    cpu_write(2'd2, 8'h00);
    check("t4_irq_kept", 32'(bus.o_irq), 1);
    cpu_read(2'd1, 8'h90, "t4_status_valid");
    cpu_read(2'd0, 8'd5, "t4_vector5");
    bus.i_pending = '0;
    expect_eoi(8'd5, "t4_eoi5");
    cpu_write(2'd2, 8'h00);

    // 5) clear enable in INSVC, then in VALID
    pend_only(12);
    wait_irq(1'b1, 40, "t5_irq12");
    cpu_read(2'd0, 8'd12, "t5_vector12");
    cpu_write(2'd3, 8'h00);
    cpu_read(2'd1, 8'h40, "t5_status_insvc_dis");
    cpu_read(2'd3, 8'h00, "t5_ctrl");
    bus.i_pending = '0;
    expect_eoi(8'd12, "t5_eoi12");
    cpu_write(2'd2, 8'h00);
    cpu_read(2'd1, 8'h00, "t5_status_idle");
    cpu_write(2'd3, 8'h01);
    pend_only(3);
    wait_irq(1'b1, 40, "t5_irq3");
    cpu_write(2'd3, 8'h00);
    check("t5_irq_dis", 32'(bus.o_irq), 0);
    cpu_read(2'd1, 8'h00, "t5_status_dis");
    bus.i_pending = '0;

    // 6) reset during SCAN and during INSVC
    cpu_write(2'd3, 8'h01);
    cpu_read(2'd1, 8'h30, "t6_status_scan");
    pulse_reset();
    check("t6a_irq", 32'(bus.o_irq), 0);
    check("t6a_eoi", 32'(bus.o_eoi), 0);
    check("t6a_eoi_num", 32'(bus.o_eoi_num), 0);
    cpu_read(2'd1, 8'h00, "t6a_status");
    cpu_read(2'd3, 8'h00, "t6a_ctrl");
    cpu_write(2'd3, 8'h01);
    pend_only(7);
    wait_irq(1'b1, 40, "t6b_irq7");
    cpu_read(2'd0, 8'd7, "t6b_vector7");
    cpu_read(2'd1, 8'h50, "t6b_status_insvc");
    bus.i_pending = '0;
    pulse_reset();
    check("t6b_irq", 32'(bus.o_irq), 0);
    check("t6b_eoi", 32'(bus.o_eoi), 0);
    cpu_read(2'd1, 8'h00, "t6b_status");
    cpu_read(2'd0, 8'h00, "t6b_vector");
    repeat (4) tick();

    check("queues_drained", 32'(rd_q.size() + eoi_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
